// File: rtl/axi_dma_pkg.sv
// Shared AXI DMA definitions: burst/response encodings, the 4 KB boundary
// and the read-engine FSM state type.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: picks the largest INCR burst that fits the
// remaining beats, the maximum burst length and the distance to the next
// 4 KB page. Shared between the read and write engines.
module axi_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic [11:0] i_addr_lo,
  input  logic [31:0] i_remain_beats,
  output logic [8:0]  o_beats,
  output logic [7:0]  o_arlen
);

  localparam int BPB      = DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam logic [31:0] MAX_BEATS = 32'(MAX_BURST_BEATS);

  logic [12:0] bytes_to_4k;
  logic [31:0] beats_to_4k;
  logic [31:0] limit;

  // Minimum of remaining beats, burst cap and beats left in this 4 KB page
  always_comb begin
    bytes_to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, i_addr_lo};
    beats_to_4k = 32'(bytes_to_4k >> BPB_LOG2);
    limit       = i_remain_beats;
    if (MAX_BEATS < limit) begin
      limit = MAX_BEATS;
    end
    if (beats_to_4k < limit) begin
      limit = beats_to_4k;
    end
    o_beats = limit[8:0];
    o_arlen = (limit == 32'd0) ? 8'd0 : 8'(limit - 32'd1);
  end

endmodule

// File: rtl/axi_burst_read_engine.sv
// AXI4 read master for the DMA: splits a byte range into INCR bursts that
// never cross 4 KB, keeps several bursts outstanding and streams returned
// beats into the DMA data FIFO.
module axi_burst_read_engine
  import axi_dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST_BEATS    = 16,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_busy,
  output logic                          o_read_done,
  output logic                          o_read_err,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_push,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int BPB      = C_M_AXI_DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(C_M_AXI_ADDR_WIDTH'(BPB - 1));

  rd_state_e                   state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                 remain_q, remain_d;
  logic [7:0]                  arlen_q, arlen_d;
  logic                        arvalid_q, arvalid_d;
  logic [OUT_W-1:0]            outstanding_q, outstanding_d;
  logic                        err_q, err_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0] calc_addr;
  logic [31:0]                 calc_remain;
  logic [8:0]                  calc_beats;
  logic [7:0]                  calc_arlen;
  logic [8:0]                  cur_beats;
  logic                        rready;
  logic                        ar_hs;
  logic                        r_hs;
  logic                        rlast_hs;
  logic                        r_err;

  // The sizing logic sees the address/remaining count that will be current
  // next cycle, so arlen is ready alongside a back-to-back arvalid.
  axi_burst_calc #(
    .DATA_WIDTH      (C_M_AXI_DATA_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_calc (
    .i_addr_lo      (calc_addr[11:0]),
    .i_remain_beats (calc_remain),
    .o_beats        (calc_beats),
    .o_arlen        (calc_arlen)
  );

  // Handshake decode for both AXI channels
  always_comb begin
    rready    = (state_q == ST_RUN) && !i_fifo_full;
    ar_hs     = arvalid_q && m_axi_arready;
    r_hs      = m_axi_rvalid && rready;
    rlast_hs  = r_hs && m_axi_rlast;
    r_err     = (m_axi_rresp == AXI_RESP_SLVERR) || (m_axi_rresp == AXI_RESP_DECERR);
    cur_beats = {1'b0, arlen_q} + 9'd1;
  end

  // FSM next state plus issue/receive bookkeeping
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    calc_addr     = addr_q;
    calc_remain   = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d       = ST_RUN;
          calc_addr     = i_src_addr & ADDR_MASK;
          calc_remain   = i_total_len >> BPB_LOG2;
          outstanding_d = '0;
          err_d         = 1'b0;
        end
      end
      ST_RUN: begin
        if (ar_hs) begin
          calc_addr   = addr_q + (C_M_AXI_ADDR_WIDTH'(cur_beats) << BPB_LOG2);
          calc_remain = remain_q - 32'(cur_beats);
        end
        case ({ar_hs, rlast_hs})
          2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
          2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
          default: outstanding_d = outstanding_q;
        endcase
        if (r_hs && r_err) begin
          err_d = 1'b1;
        end
        if ((calc_remain == 32'd0) && (outstanding_d == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    addr_d    = calc_addr;
    remain_d  = calc_remain;
    arvalid_d = (state_d == ST_RUN) && (calc_beats != 9'd0) && (outstanding_d < OUT_MAX);
  end

  // Burst length for the request presented next cycle
  always_comb begin
    arlen_d = calc_arlen;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      arlen_q       <= arlen_d;
      arvalid_q     <= arvalid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(BPB_LOG2);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready;
  assign o_fifo_push   = r_hs;
  assign o_r_data      = m_axi_rdata;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_read_done   = (state_q == ST_DONE);
  assign o_read_err    = err_q;

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// Directed bench for axi_burst_read_engine: a 32-bit instance with two
// outstanding bursts against a simple AXI read slave, plus a 64-bit
// instance for the zero-length case.
module tb_axi_burst_read_engine;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_busy;
  logic        o_read_done;
  logic        o_read_err;
  logic        i_fifo_full;
  logic        o_fifo_push;
  logic [31:0] o_r_data;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  logic        b_start;
  logic [31:0] b_src_addr;
  logic [31:0] b_total_len;
  logic        b_busy;
  logic        b_done;
  logic        b_err;
  logic        b_fifo_full;
  logic        b_push;
  logic [63:0] b_r_data;
  logic [31:0] b_araddr;
  logic [7:0]  b_arlen;
  logic [2:0]  b_arsize;
  logic [1:0]  b_arburst;
  logic        b_arvalid;
  logic        b_arready;
  logic [63:0] b_rdata;
  logic [1:0]  b_rresp;
  logic        b_rlast;
  logic        b_rvalid;
  logic        b_rready;

  int tests;
  int fails;

  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  int          ar_rl_log[$];
  logic [31:0] pend_addr[$];
  logic [7:0]  pend_len[$];
  logic [31:0] push_log[$];
  int          rlast_cnt;
  int          done_cnt;
  int          cyc;
  int          last_rlast_cyc;
  int          done_cyc;
  int          beat_idx;
  int          gbeat;
  int          err_beat;
  logic        r_taken;
  logic        r_enable;

  axi_burst_read_engine #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .MAX_BURST_BEATS    (16),
    .MAX_OUTSTANDING    (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_src_addr    (i_src_addr),
    .i_total_len   (i_total_len),
    .o_busy        (o_busy),
    .o_read_done   (o_read_done),
    .o_read_err    (o_read_err),
    .i_fifo_full   (i_fifo_full),
    .o_fifo_push   (o_fifo_push),
    .o_r_data      (o_r_data),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  axi_burst_read_engine #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (64),
    .MAX_BURST_BEATS    (16),
    .MAX_OUTSTANDING    (4)
  ) dut64 (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (b_start),
    .i_src_addr    (b_src_addr),
    .i_total_len   (b_total_len),
    .o_busy        (b_busy),
    .o_read_done   (b_done),
    .o_read_err    (b_err),
    .i_fifo_full   (b_fifo_full),
    .o_fifo_push   (b_push),
    .o_r_data      (b_r_data),
    .m_axi_araddr  (b_araddr),
    .m_axi_arlen   (b_arlen),
    .m_axi_arsize  (b_arsize),
    .m_axi_arburst (b_arburst),
    .m_axi_arvalid (b_arvalid),
    .m_axi_arready (b_arready),
    .m_axi_rdata   (b_rdata),
    .m_axi_rresp   (b_rresp),
    .m_axi_rlast   (b_rlast),
    .m_axi_rvalid  (b_rvalid),
    .m_axi_rready  (b_rready)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record handshakes at the clock edge they complete on
  always @(posedge clk) begin
    if (m_axi_arvalid && m_axi_arready) begin
      ar_addr_log.push_back(m_axi_araddr);
      ar_len_log.push_back(m_axi_arlen);
      ar_rl_log.push_back(rlast_cnt);
      pend_addr.push_back(m_axi_araddr);
      pend_len.push_back(m_axi_arlen);
    end
    if (m_axi_rvalid && m_axi_rready) begin
      r_taken = 1'b1;
      if (m_axi_rlast) begin
        rlast_cnt++;
        last_rlast_cyc = cyc;
      end
    end
    if (o_fifo_push) begin
      push_log.push_back(o_r_data);
    end
    if (o_read_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  // Read slave: returns each burst in order, data = beat byte address
  always @(negedge clk) begin
    if (r_taken) begin
      r_taken = 1'b0;
      gbeat++;
      if (pend_addr.size() > 0) begin
        if (beat_idx == int'(pend_len[0])) begin
          void'(pend_addr.pop_front());
          void'(pend_len.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
    end
    if (r_enable && pend_addr.size() > 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pend_addr[0] + 32'(beat_idx * 4);
      m_axi_rlast  = (beat_idx == int'(pend_len[0]));
      m_axi_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
    @(negedge clk);
    i_src_addr  = addr;
    i_total_len = len;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && o_busy; i++) begin
      @(negedge clk);
    end
    checkOutput("idle_within_budget", {63'd0, o_busy}, 64'd0);
  endtask

  task automatic clearLogs();
    #2;
    ar_addr_log.delete();
    ar_len_log.delete();
    ar_rl_log.delete();
    pend_addr.delete();
    pend_len.delete();
    push_log.delete();
    rlast_cnt      = 0;
    done_cnt       = 0;
    last_rlast_cyc = -100;
    done_cyc       = -200;
    beat_idx       = 0;
    gbeat          = 0;
    r_taken        = 1'b0;
    m_axi_rvalid   = 1'b0;
    m_axi_rlast    = 1'b0;
  endtask

  function automatic logic [31:0] arAddrAt(input int i);
    return (ar_addr_log.size() > i) ? ar_addr_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [7:0] arLenAt(input int i);
    return (ar_len_log.size() > i) ? ar_len_log[i] : 8'hEE;
  endfunction

  function automatic int arRlAt(input int i);
    return (ar_rl_log.size() > i) ? ar_rl_log[i] : -1;
  endfunction

  task automatic checkData(input logic [31:0] base, input int nbeats);
    checkOutput("push_count", 64'(push_log.size()), 64'(nbeats));
    for (int i = 0; i < nbeats && i < push_log.size(); i++) begin
      checkOutput($sformatf("push_data[%0d]", i), 64'(push_log[i]), 64'(base + 32'(4 * i)));
    end
  endtask

  // Directed sequence
  initial begin
    tests = 0; fails = 0; cyc = 0;
    reset_n = 1'b0; i_start = 1'b0; i_src_addr = '0; i_total_len = '0;
    i_fifo_full = 1'b0; m_axi_arready = 1'b1; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    r_enable = 1'b0; err_beat = -1;
    b_start = 1'b0; b_src_addr = '0; b_total_len = '0; b_fifo_full = 1'b0;
    b_arready = 1'b1; b_rdata = '0; b_rresp = 2'b00; b_rlast = 1'b0; b_rvalid = 1'b0;
    clearLogs();
    #1;

    // Reset values
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_arvalid", m_axi_arvalid, 0);
    checkOutput("rst_rready", m_axi_rready, 0);
    checkOutput("rst_push", o_fifo_push, 0);
    checkOutput("rst_done", o_read_done, 0);
    checkOutput("rst_err", o_read_err, 0);
    checkOutput("rst_araddr", m_axi_araddr, 0);
    checkOutput("rst_arlen", m_axi_arlen, 0);
    checkOutput("arsize32", m_axi_arsize, 2);
    checkOutput("arburst32", m_axi_arburst, 1);
    checkOutput("rst64_busy", b_busy, 0);
    checkOutput("rst64_arvalid", b_arvalid, 0);
    checkOutput("rst64_rready", b_rready, 0);
    checkOutput("rst64_push", b_push, 0);
    checkOutput("rst64_err", b_err, 0);
    checkOutput("rst64_araddr", b_araddr, 0);
    checkOutput("rst64_arlen", b_arlen, 0);
    checkOutput("rst64_rdata", b_r_data, 0);
    checkOutput("arsize64", b_arsize, 3);
    checkOutput("arburst64", b_arburst, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 0x1000, 256 bytes: four 16-beat bursts
    r_enable = 1'b1;
    applyStimulus(32'h1000, 32'd256);
    checkOutput("t1_busy_c1", o_busy, 1);
    checkOutput("t1_arvalid_c1", m_axi_arvalid, 1);
    checkOutput("t1_araddr_c1", m_axi_araddr, 32'h1000);
    checkOutput("t1_arlen_c1", m_axi_arlen, 15);
    checkOutput("t1_rready_c1", m_axi_rready, 1);
    waitIdle(400);
    checkOutput("t1_ar_count", 64'(ar_addr_log.size()), 4);
    checkOutput("t1_ar0", arAddrAt(0), 32'h1000);
    checkOutput("t1_ar1", arAddrAt(1), 32'h1040);
    checkOutput("t1_ar2", arAddrAt(2), 32'h1080);
    checkOutput("t1_ar3", arAddrAt(3), 32'h10C0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_len%0d", i), arLenAt(i), 15);
    checkData(32'h1000, 64);
    checkOutput("t1_done_count", 64'(done_cnt), 1);
    checkOutput("t1_done_after_rlast", 64'(done_cyc), 64'(last_rlast_cyc + 1));
    checkOutput("t1_done_low", o_read_done, 0);
    clearLogs();

    // 0x0FF0, 64 bytes: split at the 4 KB page
    applyStimulus(32'h0FF0, 32'd64);
    waitIdle(200);
    checkOutput("t2_ar_count", 64'(ar_addr_log.size()), 2);
    checkOutput("t2_ar0", arAddrAt(0), 32'h0FF0);
    checkOutput("t2_len0", arLenAt(0), 3);
    checkOutput("t2_ar1", arAddrAt(1), 32'h1000);
    checkOutput("t2_len1", arLenAt(1), 11);
    checkData(32'h0FF0, 16);
    clearLogs();

    // Outstanding limit of two with read data withheld
    r_enable = 1'b0;
    applyStimulus(32'h2000, 32'd256);
    repeat (10) @(negedge clk);
    checkOutput("t3_ar_count_held", 64'(ar_addr_log.size()), 2);
    checkOutput("t3_arvalid_held", m_axi_arvalid, 0);
    checkOutput("t3_ar0", arAddrAt(0), 32'h2000);
    checkOutput("t3_ar1", arAddrAt(1), 32'h2040);
    r_enable = 1'b1;
    waitIdle(400);
    checkOutput("t3_ar_count", 64'(ar_addr_log.size()), 4);
    checkOutput("t3_ar2", arAddrAt(2), 32'h2080);
    checkOutput("t3_ar3", arAddrAt(3), 32'h20C0);
    checkOutput("t3_ar2_after_rlast1", 64'(arRlAt(2)), 1);
    checkOutput("t3_ar3_after_rlast2", 64'(arRlAt(3)), 2);
    checkData(32'h2000, 64);
    clearLogs();

    // AR held under arready low, then FIFO backpressure every other cycle
    m_axi_arready = 1'b0;
    applyStimulus(32'h3000, 32'd128);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_arvalid_hold", m_axi_arvalid, 1);
      checkOutput("t4_araddr_hold", m_axi_araddr, 32'h3000);
      checkOutput("t4_arlen_hold", m_axi_arlen, 15);
      @(negedge clk);
    end
    m_axi_arready = 1'b1;
    for (int i = 0; i < 400 && o_busy; i++) begin
      @(negedge clk);
      i_fifo_full = ~i_fifo_full;
      #1;
      if (o_busy && !o_read_done) begin
        checkOutput("t4_rready_tracks_full", m_axi_rready, !i_fifo_full);
      end
    end
    i_fifo_full = 1'b0;
    waitIdle(50);
    checkOutput("t4_ar0", arAddrAt(0), 32'h3000);
    checkOutput("t4_ar1", arAddrAt(1), 32'h3040);
    checkData(32'h3000, 32);
    clearLogs();

    // Beat 5 answered with SLVERR
    err_beat = 5;
    applyStimulus(32'h4000, 32'd64);
    checkOutput("t5_err_start", o_read_err, 0);
    for (int i = 0; i < 300 && !o_read_done; i++) @(negedge clk);
    checkOutput("t5_done_pulse", o_read_done, 1);
    checkOutput("t5_err_at_done", o_read_err, 1);
    waitIdle(20);
    checkOutput("t5_err_sticky", o_read_err, 1);
    checkData(32'h4000, 16);
    err_beat = -1;
    clearLogs();

    // Next start clears the error
    applyStimulus(32'h5000, 32'd4);
    checkOutput("t6_err_cleared", o_read_err, 0);
    waitIdle(50);
    checkOutput("t6_ar_len", arLenAt(0), 0);
    checkData(32'h5000, 1);
    clearLogs();

    // 64-bit instance, zero length: no AR, done at cycle 2
    @(negedge clk);
    b_src_addr  = 32'h100;
    b_total_len = 32'd0;
    b_start     = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checkOutput("t7_busy_c1", b_busy, 1);
    checkOutput("t7_arvalid_c1", b_arvalid, 0);
    checkOutput("t7_done_c1", b_done, 0);
    @(negedge clk);
    checkOutput("t7_done_c2", b_done, 1);
    checkOutput("t7_arvalid_c2", b_arvalid, 0);
    @(negedge clk);
    checkOutput("t7_done_c3", b_done, 0);
    checkOutput("t7_busy_c3", b_busy, 0);
    checkOutput("t7_err", b_err, 0);

    // Asynchronous reset in the middle of a transfer
    applyStimulus(32'h6000, 32'd256);
    repeat (10) @(negedge clk);
    #2;
    checkOutput("t8_busy_before", o_busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t8_busy", o_busy, 0);
    checkOutput("t8_arvalid", m_axi_arvalid, 0);
    checkOutput("t8_rready", m_axi_rready, 0);
    checkOutput("t8_push", o_fifo_push, 0);
    checkOutput("t8_done", o_read_done, 0);
    checkOutput("t8_err", o_read_err, 0);
    checkOutput("t8_araddr", m_axi_araddr, 0);
    checkOutput("t8_arlen", m_axi_arlen, 0);
    r_enable = 1'b0;
    clearLogs();
    @(negedge clk);
    reset_n = 1'b1;
    r_enable = 1'b1;

    // Clean transfer after reset
    applyStimulus(32'h7000, 32'd8);
    checkOutput("t9_araddr_c1", m_axi_araddr, 32'h7000);
    checkOutput("t9_arlen_c1", m_axi_arlen, 1);
    waitIdle(100);
    checkData(32'h7000, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
